// File: rtl/cla_add_pipe.sv
// Two-stage valid/ready add/subtract unit: stage 1 holds operands feeding a block CLA, stage 2 holds result and flags.
// Optional saturation on signed overflow is enabled by defining CLA_ADD_PIPE_SAT_EN.
module cla_add_pipe #(
    parameter  int N_BLOCKS = 4,
    localparam int W        = 4 * N_BLOCKS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         c_out,
    output logic         ovf,
    output logic         zero
);

    // 4-bit lookahead block: returns {carry_out, sum[3:0]}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] z, input logic ci);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & z;
        p    = x ^ z;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_a_q, s1_a_d;
    logic [W-1:0] s1_b_q, s1_b_d;
    logic         s1_cin_q, s1_cin_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] y_q, y_d;
    logic         c_out_q, c_out_d;
    logic         ovf_q, ovf_d;
    logic         zero_q, zero_d;

    logic              s2_load_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic [W-1:0]      sum_s;
    logic [N_BLOCKS:0] blk_c_s;
    logic [4:0]        blk_res_s;
    logic              ovf_s;

    // Handshake decode; in_ready is gated by rst_n so it reads 0 throughout reset
    always_comb begin
        s2_load_s  = s1_valid_q & (~s2_valid_q | out_ready);
        in_ready   = rst_n & (~s1_valid_q | s2_load_s);
        in_fire_s  = in_valid & in_ready;
        out_fire_s = s2_valid_q & out_ready;
    end

    // Block carry chain across the 4-bit lookahead blocks
    always_comb begin
        sum_s      = {W{1'b0}};
        blk_c_s    = {(N_BLOCKS + 1){1'b0}};
        blk_res_s  = 5'b0_0000;
        blk_c_s[0] = s1_cin_q;
        for (int i = 0; i < N_BLOCKS; i++) begin
            blk_res_s          = cla4(s1_a_q[4*i +: 4], s1_b_q[4*i +: 4], blk_c_s[i]);
            sum_s[4*i +: 4]    = blk_res_s[3:0];
            blk_c_s[i+1]       = blk_res_s[4];
        end
    end

    // Stage-2 result and flags derived from the stage-1 sum
    always_comb begin
        ovf_s   = (s1_a_q[W-1] == s1_b_q[W-1]) & (sum_s[W-1] != s1_a_q[W-1]);
        c_out_d = blk_c_s[N_BLOCKS];
        ovf_d   = ovf_s;
`ifdef CLA_ADD_PIPE_SAT_EN
        if (ovf_s) begin
            y_d = s1_a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y_d = sum_s;
        end
`else
        y_d = sum_s;
`endif
        zero_d = (y_d == {W{1'b0}});
    end

    // Next-state for both pipeline stages; registers hold unless their stage loads
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_cin_d   = s1_cin_q;
        s2_valid_d = s2_valid_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = sub ? ~b : b;
            s1_cin_d   = sub ? ~c_in : c_in;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            s2_valid_d = 1'b1;
        end else if (out_fire_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage-1 operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {W{1'b0}};
            s1_b_q     <= {W{1'b0}};
            s1_cin_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_cin_q   <= s1_cin_d;
        end
    end

    // Stage-2 result registers; data only changes on a stage-2 load so it holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            y_q        <= {W{1'b0}};
            c_out_q    <= 1'b0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load_s) begin
                y_q     <= y_d;
                c_out_q <= c_out_d;
                ovf_q   <= ovf_d;
                zero_q  <= zero_d;
            end else begin
                y_q     <= y_q;
                c_out_q <= c_out_q;
                ovf_q   <= ovf_q;
                zero_q  <= zero_q;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign y         = y_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe (N_BLOCKS=4, W=16): directed vector table, handshake sequences,
// reset cases and a randomized stream checked against an arithmetic scoreboard model.
module tb_cla_add_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         c_out;
    logic         ovf;
    logic         zero;

    cla_add_pipe #(.N_BLOCKS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         ovf;
        logic         zero;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c_in;
        logic         sub;
        logic [W-1:0] y;
        logic         c;
        logic         ovf;
        logic         zero;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   retired = 0;
    res_t last_out;
    res_t sb[$];
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands as written
    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic mc, input logic ms);
        longint full;
        longint sres;
        res_t   r;
        if (!ms) begin
            full = longint'(ma) + longint'(mb) + longint'(mc);
            sres = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
            r.c  = (full >= 65536);
        end else begin
            full = longint'(ma) - longint'(mb) - longint'(mc);
            sres = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mc);
            r.c  = (full >= 0);
        end
        r.ovf = (sres > 32767) || (sres < -32768);
        r.y   = full[15:0];
`ifdef CLA_ADD_PIPE_SAT_EN
        if (r.ovf) r.y = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
        r.zero = (r.y == 16'h0000);
        return r;
    endfunction

    // One clock cycle: drive inputs, check handshake and scoreboard, then check hold behaviour
    task automatic tick(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic isub, input logic orr);
        res_t exp;
        logic hv;
        res_t held;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        c_in      = ic;
        sub       = isub;
        out_ready = orr;
        #1;
        chk("in_ready", in_ready, !(sb.size() == 2 && !orr));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: got y=%h with no beat in flight, expected none", y);
            end else begin
                exp = sb.pop_front();
                chk("out_data", {y, c_out, ovf, zero}, exp);
                last_out = {y, c_out, ovf, zero};
                retired++;
            end
        end
        if (in_valid && in_ready) sb.push_back(model(ia, ib, ic, isub));
        hv   = out_valid && !out_ready;
        held = {y, c_out, ovf, zero};
        @(negedge clk);
        if (hv) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", {y, c_out, ovf, zero}, held);
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        vecs[0] = '{16'h1234, 16'h0FCC, 1'b0, 1'b0, 16'h2200, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h0010, 16'h0010, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
`ifdef CLA_ADD_PIPE_SAT_EN
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
`else
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
`endif

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", {y, c_out, ovf, zero}, '0);
        chk("rst_in_ready", in_ready, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);

        // Directed table: accept, check two-edge latency, then compare retired beat
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub, 1'b1);
            chk("lat_early", out_valid, 1'b0);
            tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("lat_valid", out_valid, 1'b1);
            tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk($sformatf("vec%0d", i), last_out, {vecs[i].y, vecs[i].c, vecs[i].ovf, vecs[i].zero});
        end

        // Backpressure: third beat stalls, result 1 holds, then 1,2,3 retire on consecutive cycles
        begin
            int r0;
            tick(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
            tick(1'b1, 16'h0002, 16'h0002, 1'b0, 1'b0, 1'b0);
            tick(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
            chk("bp_in_ready", in_ready, 1'b0);
            tick(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
            tick(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0);
            chk("bp_y_hold", y, 16'h0002);
            r0 = retired;
            tick(1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b1);
            tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("bp_retired", retired - r0, 3);
            chk("bp_last_y", last_out.y, 16'h0006);
            chk("bp_drained", sb.size(), 0);
        end

        // Randomized stream with random valid/ready patterns
        for (int i = 0; i < 2000; i++) begin
            tick(($urandom_range(0, 3) != 0), pick(), pick(), 1'(($urandom_range(0, 1))),
                 1'(($urandom_range(0, 1))), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("rand_drained", sb.size(), 0);

        // Reset mid-stream with both stages full
        tick(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_out_data", {y, c_out, ovf, zero}, '0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        sb.delete();
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("no_stale", out_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
